// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, frame constants, address helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_loader_pkg;

    // Loader FSM states. S_ERR is a one-cycle state that flags the fault and
    // behaves like S_IDLE, so a MAGIC arriving right after an abort is not lost.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CNT0    = 3'd1,
        S_CNT1    = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHECK   = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    // Frame layout: MAGIC, CNT_LO, CNT_HI, 4*N payload bytes (LSB first), CHK.
    localparam logic [7:0] MAGIC_DEFAULT   = 8'hA5;
    localparam int         DEPTH_DEFAULT   = 256;
    localparam int         TIMEOUT_DEFAULT = 1000000;
    localparam int         COUNT_W         = 16;     // width of the N field
    localparam logic [1:0] LAST_LANE       = 2'd3;   // byte lane that completes a word

    // Byte address of an instruction word.
    function automatic logic [31:0] word_addr(input logic [COUNT_W-1:0] idx);
        return {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Loadable down-counter: reloads on clear, counts down while enabled, pulses expire at zero.
// Latency: expire is combinational from the count; it asserts in the cycle the count sits at 0.
// Backpressure: none; clear always wins over expiry so a byte arriving on the last cycle is kept.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset (count -> 0)
//   clear           - reload the counter with load_val (one pulse per received byte)
//   en              - count down this cycle (only while a frame is in progress)
//   load_val        - reload value; expiry happens load_val+1 enabled cycles after clear
//   expire          - one-cycle pulse when the enabled count reaches 0 without a clear
module loader_timeout #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q;

    assign expire = en && !clear && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Frames a UART byte stream into 32-bit LE words and writes them to instruction memory, holding the core in reset until a good image lands.
// Latency: write strobe asserts 1 cycle after the 4th byte of each word; done/error update 1 cycle after the deciding byte.
// Backpressure: none; accepts one byte per cycle, inter-byte gaps longer than TIMEOUT_CYCLES-1 abort the frame.
//
// Ports:
//   clk, reset         - clock, synchronous active-high reset (back to IDLE, core held)
//   rx_valid, rx_byte  - one-cycle byte strobe and byte from the UART receiver
//   write              - one-cycle instruction-memory write strobe
//   addr_in, data      - byte address and word for the write; held between strobes
//   cpu_reset          - holds the core in reset while high
//   done               - image loaded and checksum good; cleared by the next MAGIC
//   error              - sticky fault flag; cleared by the next MAGIC
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         DEPTH          = DEPTH_DEFAULT,
    parameter int         TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter logic [7:0] MAGIC          = MAGIC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        write,
    output logic [31:0] addr_in,
    output logic [31:0] data,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [7:0]           cnt_lo_q, cnt_lo_d;
    logic [COUNT_W-1:0]   n_q, n_d;
    logic [COUNT_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]           byte_idx_q, byte_idx_d;
    logic [7:0]           sum_q, sum_d;
    // Only lanes 0..2 are buffered; lane 3 goes straight from rx_byte into data.
    logic [23:0]          wbuf_q, wbuf_d;
    logic                 write_q, write_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic                 cpu_reset_q, cpu_reset_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic [COUNT_W-1:0]   hdr_n;
    logic                 in_frame;
    logic                 to_expire;

    assign hdr_n    = {rx_byte, cnt_lo_q};
    assign in_frame = (state_q == S_CNT0) || (state_q == S_CNT1) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CHECK);

    loader_timeout #(
        .W(TW)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (rx_valid),
        .en       (in_frame),
        .load_val (TO_LOAD),
        .expire   (to_expire)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_lo_q    <= '0;
            n_q         <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            sum_q       <= '0;
            wbuf_q      <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_lo_q    <= cnt_lo_d;
            n_q         <= n_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            sum_q       <= sum_d;
            wbuf_q      <= wbuf_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        cnt_lo_d    = cnt_lo_q;
        n_d         = n_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        sum_d       = sum_q;
        wbuf_d      = wbuf_q;
        write_d     = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (state_q == S_ERR) begin
                    state_d = S_IDLE;
                end
                if (rx_valid && (rx_byte == MAGIC)) begin
                    state_d     = S_CNT0;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                end
            end

            S_CNT0: begin
                if (rx_valid) begin
                    cnt_lo_d = rx_byte;
                    state_d  = S_CNT1;
                end
            end

            S_CNT1: begin
                if (rx_valid) begin
                    n_d = hdr_n;
                    if ((hdr_n == '0) || (32'(hdr_n) > DEPTH)) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d    = S_PAYLOAD;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        sum_d      = '0;
                    end
                end
            end

            S_PAYLOAD: begin
                // MAGIC is plain data here: no mid-frame resynchronisation.
                if (rx_valid) begin
                    sum_d      = sum_q + rx_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: wbuf_d[7:0]   = rx_byte;
                        2'd1: wbuf_d[15:8]  = rx_byte;
                        2'd2: wbuf_d[23:16] = rx_byte;
                        default: begin
                            write_d    = 1'b1;
                            data_d     = {rx_byte, wbuf_q};
                            addr_d     = word_addr(word_idx_q);
                            word_idx_d = word_idx_q + 16'd1;
                            if (word_idx_q == (n_q - 16'd1)) begin
                                state_d = S_CHECK;
                            end
                        end
                    endcase
                end
            end

            S_CHECK: begin
                if (rx_valid) begin
                    if (rx_byte == sum_q) begin
                        state_d     = S_DONE;
                        cpu_reset_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Expiry only fires on a cycle with no byte, so it never collides with
        // a write or a checksum decision above. Written words stay in memory.
        if (to_expire) begin
            state_d = S_ERR;
            error_d = 1'b1;
        end
    end

    // byte_idx wraps 3 -> 0 naturally; LAST_LANE documents the completing lane.
    logic unused_lane;
    assign unused_lane = (LAST_LANE == 2'd3);

    assign write     = write_q;
    assign addr_in   = addr_q;
    assign data      = data_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int         DEPTH = 256;
    localparam int         TMO   = 16;
    localparam logic [7:0] MAGIC = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        write;
    logic [31:0] addr_in;
    logic [31:0] data;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    logic [31:0] fw [0:DEPTH-1];
    logic [31:0] last_addr;
    logic [31:0] last_data;

    typedef struct {
        logic [15:0] cnt;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [7:0]  adj;
        logic        e_done;
        logic        e_err;
        logic        e_cr;
    } vec_t;

    vec_t tbl [8];

    imem_loader #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .MAGIC          (MAGIC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .write     (write),
        .addr_in   (addr_in),
        .data      (data),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic d, input logic e, input logic cr);
        chk({tag, ".done"},      {31'd0, done},      {31'd0, d});
        chk({tag, ".error"},     {31'd0, error},     {31'd0, e});
        chk({tag, ".cpu_reset"}, {31'd0, cpu_reset}, {31'd0, cr});
    endtask

    // One clock: drive inputs, let the edge pass, sample 1ns later.
    task automatic tick(input logic v, input logic [7:0] b, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
        rx_valid = v;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        chk("write", {31'd0, write}, {31'd0, wr});
        if (wr) begin
            chk("addr_in", addr_in, a);
            chk("data", data, d);
            last_addr = a;
            last_data = d;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic gap(input int m);
        if (m > 0) idle(int'($urandom_range(m, 0)));
    endtask

    // Sends a frame built from fw[0..nw-1]; CHK is sent only if payload was sent.
    task automatic frame(input logic [15:0] cnt, input int nw, input logic [7:0] adj, input int max_gap);
        logic [7:0]  sum;
        logic [31:0] w;
        logic [7:0]  bt;
        sum = 8'd0;
        tick(1'b1, MAGIC, 1'b0, 32'd0, 32'd0);
        chk_flags("after_magic", 1'b0, 1'b0, 1'b1);
        gap(max_gap);
        tick(1'b1, cnt[7:0], 1'b0, 32'd0, 32'd0);
        gap(max_gap);
        tick(1'b1, cnt[15:8], 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < nw; i++) begin
            w = fw[i];
            for (int k = 0; k < 4; k++) begin
                bt  = w[8*k +: 8];
                sum = sum + bt;
                gap(max_gap);
                tick(1'b1, bt, k == 3, i * 4, w);
            end
        end
        if (nw > 0) begin
            gap(max_gap);
            tick(1'b1, sum + adj, 1'b0, 32'd0, 32'd0);
        end
    endtask

    initial begin
        logic [15:0] cnt;
        int          nw;
        logic [7:0]  adj;
        logic [7:0]  bt;
        logic        good;
        logic        valid_cnt;

        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_byte   = 8'h00;
        last_addr = 32'd0;
        last_data = 32'd0;

        tbl[0] = '{16'd1,     1, 32'h00000013, 32'h0,        32'h0,        8'd0,  1'b1, 1'b0, 1'b0};
        tbl[1] = '{16'd2,     2, 32'hfe010113, 32'h00112e23, 32'h0,        8'd0,  1'b1, 1'b0, 1'b0};
        tbl[2] = '{16'd2,     2, 32'hfe010113, 32'h00112e23, 32'h0,        8'd1,  1'b0, 1'b1, 1'b1};
        tbl[3] = '{16'h0101,  0, 32'h0,        32'h0,        32'h0,        8'd0,  1'b0, 1'b1, 1'b1};
        tbl[4] = '{16'd1,     1, 32'ha5a5a5a5, 32'h0,        32'h0,        8'd0,  1'b1, 1'b0, 1'b0};
        tbl[5] = '{16'd0,     0, 32'h0,        32'h0,        32'h0,        8'd0,  1'b0, 1'b1, 1'b1};
        tbl[6] = '{16'd3,     3, 32'h11223344, 32'haabbccdd, 32'ha5000001, 8'hff, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{16'd3,     3, 32'h11223344, 32'haabbccdd, 32'ha5000001, 8'd0,  1'b1, 1'b0, 1'b0};

        // Reset state
        idle(3);
        reset = 1'b0;
        idle(1);
        chk("reset.addr_in", addr_in, 32'd0);
        chk("reset.data", data, 32'd0);
        chk_flags("reset", 1'b0, 1'b0, 1'b1);

        // Table-driven frames, bytes back to back
        for (int t = 0; t < 8; t++) begin
            fw[0] = tbl[t].w0;
            fw[1] = tbl[t].w1;
            fw[2] = tbl[t].w2;
            frame(tbl[t].cnt, tbl[t].nw, tbl[t].adj, 0);
            chk_flags($sformatf("tbl%0d", t), tbl[t].e_done, tbl[t].e_err, tbl[t].e_cr);
            idle(2);
            if (tbl[t].nw > 0) begin
                chk($sformatf("tbl%0d.hold_addr", t), addr_in, last_addr);
                chk($sformatf("tbl%0d.hold_data", t), data, last_data);
            end
        end

        // Largest legal image: DEPTH words, last address 0x3FC
        for (int i = 0; i < DEPTH; i++) fw[i] = {8'(i) ^ 8'h5c, ~8'(i), 8'(i), 8'h3c};
        frame(16'(DEPTH), DEPTH, 8'd0, 0);
        chk_flags("full_depth", 1'b1, 1'b0, 1'b0);
        chk("full_depth.last_addr", addr_in, 32'h3FC);

        // Inter-byte timeout: two payload bytes then silence
        tick(1'b1, MAGIC, 1'b0, 32'd0, 32'd0);
        tick(1'b1, 8'h01, 1'b0, 32'd0, 32'd0);
        tick(1'b1, 8'h00, 1'b0, 32'd0, 32'd0);
        tick(1'b1, 8'h33, 1'b0, 32'd0, 32'd0);
        tick(1'b1, 8'h22, 1'b0, 32'd0, 32'd0);
        idle(TMO - 1);
        chk_flags("timeout_before", 1'b0, 1'b0, 1'b1);
        idle(1);
        chk_flags("timeout_hit", 1'b0, 1'b1, 1'b1);
        idle(4);
        chk_flags("timeout_sticky", 1'b0, 1'b1, 1'b1);

        // Reset arriving with the 4th byte of the third word drops that write
        fw[0] = 32'h01020304;
        fw[1] = 32'h05060708;
        fw[2] = 32'h090a0b0c;
        tick(1'b1, MAGIC, 1'b0, 32'd0, 32'd0);
        tick(1'b1, 8'h03, 1'b0, 32'd0, 32'd0);
        tick(1'b1, 8'h00, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) begin
                bt = fw[i][8*k +: 8];
                tick(1'b1, bt, k == 3, i * 4, fw[i]);
            end
        end
        tick(1'b1, 8'h0c, 1'b0, 32'd0, 32'd0);
        tick(1'b1, 8'h0b, 1'b0, 32'd0, 32'd0);
        tick(1'b1, 8'h0a, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        tick(1'b1, 8'h09, 1'b0, 32'd0, 32'd0);
        reset = 1'b0;
        chk_flags("midreset", 1'b0, 1'b0, 1'b1);
        chk("midreset.addr_in", addr_in, 32'd0);
        tick(1'b1, 8'h4e, 1'b0, 32'd0, 32'd0);
        idle(3);
        chk_flags("midreset_after", 1'b0, 1'b0, 1'b1);

        // Randomised frames against the frame-level model
        for (int r = 0; r < 25; r++) begin
            for (int j = 0; j < int'($urandom_range(2, 0)); j++) begin
                bt = 8'($urandom);
                if (bt == MAGIC) bt = 8'h5a;
                tick(1'b1, bt, 1'b0, 32'd0, 32'd0);
            end
            if ($urandom_range(5, 0) == 0) begin
                cnt = 16'($urandom_range(65535, DEPTH + 1));
                nw  = 0;
            end else begin
                nw  = int'($urandom_range(8, 1));
                cnt = 16'(nw);
            end
            adj = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
            for (int i = 0; i < nw; i++) fw[i] = $urandom;
            frame(cnt, nw, adj, 3);
            valid_cnt = (cnt != 16'd0) && (int'(cnt) <= DEPTH);
            good      = valid_cnt && (adj == 8'd0);
            chk_flags($sformatf("rand%0d", r), good, !good, !good);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
